// File: rtl/div_pkg.sv
// div_pkg: ratio codes, period/high-time lookup and FSM states shared by the divider controller
package div_pkg;
  localparam logic [1:0] SEL_9   = 2'd0;
  localparam logic [1:0] SEL_12  = 2'd1;
  localparam logic [1:0] SEL_80  = 2'd2;
  localparam logic [1:0] SEL_BAD = 2'd3;
  localparam int N_9   = 9;
  localparam int N_12  = 12;
  localparam int N_80  = 80;
  localparam int HI_9  = 5;
  localparam int HI_12 = 6;
  localparam int HI_80 = 40;
  typedef enum logic {RUN, PEND} state_e;
  function automatic int n_of(input logic [1:0] s);
    return s == SEL_80 ? N_80 : s == SEL_12 ? N_12 : N_9;
  endfunction
  function automatic int hi_of(input logic [1:0] s);
    return s == SEL_80 ? HI_80 : s == SEL_12 ? HI_12 : HI_9;
  endfunction
endpackage

// File: rtl/div_req_arb.sv
// div_req_arb: two-way fixed-priority grant, requester 0 wins over requester 1
module div_req_arb (
  input  logic       en_i,
  input  logic       v0_i,
  input  logic [1:0] s0_i,
  input  logic       v1_i,
  input  logic [1:0] s1_i,
  output logic       r0_o,
  output logic       r1_o,
  output logic [1:0] sel_o
);
  assign r0_o  = en_i & v0_i;
  assign r1_o  = en_i & v1_i & ~v0_i;
  assign sel_o = v0_i ? s0_i : s1_i;
endmodule

// File: rtl/div_ratio_ctrl.sv
// div_ratio_ctrl: programmable 9/12/80 clock divider with glitch-free ratio switching at period boundaries
module div_ratio_ctrl
  import div_pkg::*;
#(
  parameter int         CNT_W   = 7,
  parameter logic [1:0] DEF_SEL = SEL_9
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        VDD,
  inout  wire        VSS,
  input  logic       req0_valid,
  input  logic [1:0] req0_sel,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [1:0] req1_sel,
  output logic       req1_ready,
  output logic       div_out,
  output logic       div_tick,
  output logic [1:0] cur_sel,
  output logic       busy,
  output logic       err
);
  state_e st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, n_m1;
  logic [1:0] cur_q, cur_d, pend_q, pend_d, gsel;
  logic started_q, div_q, div_d, tick_q, tick_d, err_q, err_d;
  logic tick, acc, chg;

  div_req_arb u_arb (
    .en_i (st_q == RUN && !reset),
    .v0_i (req0_valid),
    .s0_i (req0_sel),
    .v1_i (req1_valid),
    .s1_i (req1_sel),
    .r0_o (req0_ready),
    .r1_o (req1_ready),
    .sel_o(gsel)
  );

  // outputs are decoded from next-cycle cnt/ratio so they line up with the counter they describe
  always_comb begin
    n_m1   = CNT_W'(n_of(cur_q) - 1);
    tick   = started_q && cnt_q == n_m1;
    acc    = req0_ready | req1_ready;
    chg    = acc && gsel != SEL_BAD && gsel != cur_q;
    cur_d  = (chg && tick) ? gsel : (st_q == PEND && tick) ? pend_q : cur_q;
    pend_d = (chg && !tick) ? gsel : pend_q;
    st_d   = (chg && !tick) ? PEND : (st_q == PEND && tick) ? RUN : st_q;
    err_d  = acc && gsel == SEL_BAD;
    cnt_d  = (!started_q || tick) ? '0 : cnt_q + 1'b1;
    div_d  = cnt_d < CNT_W'(hi_of(cur_d));
    tick_d = cnt_d == CNT_W'(n_of(cur_d) - 1);
  end

  // started_q holds the counter at 0 for the first post-reset edge so period 1 begins there
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q      <= RUN;
      cnt_q     <= '0;
      cur_q     <= DEF_SEL;
      pend_q    <= DEF_SEL;
      started_q <= 1'b0;
      div_q     <= 1'b0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      pend_q    <= pend_d;
      started_q <= 1'b1;
      div_q     <= div_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
    end
  end

  assign div_out  = div_q;
  assign div_tick = tick_q;
  assign cur_sel  = cur_q;
  assign busy     = st_q == PEND;
  assign err      = err_q;
endmodule

// File: tb/tb_div_ratio_ctrl.sv
// tb_div_ratio_ctrl: directed stimulus with queued expectations checked by an independent negedge monitor
module tb_div_ratio_ctrl;
  typedef struct {int len; int hi; logic [1:0] sel;} per_t;

  logic clk = 1'b0, reset = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [1:0] req0_sel = 2'd0, req1_sel = 2'd0;
  logic req0_ready, req1_ready, div_out, div_tick, busy, err;
  logic [1:0] cur_sel;
  wire vdd, vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  int checks = 0, errors = 0;
  per_t per_q[$];
  logic [1:0] rdy_q[$];
  int busy_q[$];
  bit err_q[$];

  always #5 clk = ~clk;

  div_ratio_ctrl #(.CNT_W(7), .DEF_SEL(2'd0)) dut (
    .clk(clk), .reset(reset), .VDD(vdd), .VSS(vss),
    .req0_valid(req0_valid), .req0_sel(req0_sel), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_sel(req1_sel), .req1_ready(req1_ready),
    .div_out(div_out), .div_tick(div_tick), .cur_sel(cur_sel), .busy(busy), .err(err)
  );

  // monitor: measures every period and pops queued expectations on handshakes, err pulses and busy windows
  initial begin
    int plen, phi, brun;
    bit plow, prunt;
    per_t p;
    logic [1:0] r;
    plen = 0; phi = 0; brun = 0; plow = 0; prunt = 0;
    forever begin
      @(negedge clk);
      if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
        checks++;
        if (rdy_q.size() == 0) begin
          errors++;
          $display("FAIL ready: got r0=%b r1=%b, no handshake expected", req0_ready, req1_ready);
        end else begin
          r = rdy_q.pop_front();
          if ({req0_ready, req1_ready} !== r) begin
            errors++;
            $display("FAIL ready: got r0r1=%b%b expected %b", req0_ready, req1_ready, r);
          end
        end
      end
      if (err === 1'b1) begin
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL err: got unexpected err pulse");
        end else void'(err_q.pop_front());
      end
      if (busy === 1'b1) brun++;
      else if (brun > 0) begin
        checks++;
        if (busy_q.size() == 0) begin
          errors++;
          $display("FAIL busy: got %0d busy cycles, none expected", brun);
        end else if (busy_q[0] != brun) begin
          errors++;
          $display("FAIL busy: got %0d busy cycles expected %0d", brun, busy_q[0]);
        end
        if (busy_q.size() > 0) void'(busy_q.pop_front());
        brun = 0;
      end
      if (reset) begin
        plen = 0; phi = 0; plow = 0; prunt = 0;
      end else begin
        plen++;
        if (div_out === 1'b1) begin
          phi++;
          if (plow) prunt = 1;
        end else plow = 1;
        if (div_tick === 1'b1) begin
          if (per_q.size() > 0) begin
            p = per_q.pop_front();
            checks++;
            if (plen != p.len || phi != p.hi || cur_sel !== p.sel || prunt) begin
              errors++;
              $display("FAIL period: got len=%0d hi=%0d sel=%0d runt=%0b expected len=%0d hi=%0d sel=%0d runt=0",
                       plen, phi, cur_sel, prunt, p.len, p.hi, p.sel);
            end
          end
          plen = 0; phi = 0; plow = 0; prunt = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_per(input int len, input int hi, input logic [1:0] sel);
    per_t p;
    p.len = len; p.hi = hi; p.sel = sel;
    per_q.push_back(p);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (div_tick === 1'b1) break;
    end
    if (div_tick !== 1'b1) begin
      checks++; errors++;
      $display("FAIL tick_timeout: got no div_tick within %0d cycles", n);
    end
  endtask

  task automatic wait_rdy(input int which);
    bit seen;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = (which == 0) ? (req0_ready === 1'b1) : (req1_ready === 1'b1);
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got no ready for requester %0d", which);
    end
    @(posedge clk);
    #1;
    if (which == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  initial begin
    int n;
    // reset: requests held valid must not be accepted
    req0_valid = 1'b1; req0_sel = 2'd2;
    req1_valid = 1'b1; req1_sel = 2'd1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outs", int'({div_out, div_tick, busy, err, req0_ready, req1_ready}), 0);
      chk("reset_sel", int'(cur_sel), 0);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; reset = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      chk($sformatf("first_periods_c%0d", i), int'({div_out, div_tick, cur_sel}),
          int'({(i % 9) < 5, (i % 9) == 8, 2'd0}));
    end

    // host switches 9 -> 80 mid-period
    step(1);
    push_per(9, 5, 2'd0); push_per(80, 40, 2'd2);
    step(3);
    req0_sel = 2'd2; req0_valid = 1'b1;
    rdy_q.push_back(2'b10); busy_q.push_back(5);
    wait_rdy(0);
    wait_tick(n);
    wait_tick(n);

    // simultaneous requests: host 12 wins, BIST 80 follows
    step(1);
    push_per(80, 40, 2'd2); push_per(12, 6, 2'd1); push_per(80, 40, 2'd2);
    step(2);
    req0_sel = 2'd1; req0_valid = 1'b1;
    req1_sel = 2'd2; req1_valid = 1'b1;
    rdy_q.push_back(2'b10); rdy_q.push_back(2'b01);
    busy_q.push_back(77); busy_q.push_back(11);
    wait_rdy(0);
    wait_rdy(1);
    wait_tick(n);
    wait_tick(n);

    // invalid code from BIST
    step(1);
    push_per(80, 40, 2'd2);
    step(5);
    req1_sel = 2'd3; req1_valid = 1'b1;
    rdy_q.push_back(2'b01); err_q.push_back(1'b1);
    wait_rdy(1);
    @(negedge clk);
    chk("bad_code_sel", int'(cur_sel), 2);
    chk("bad_code_busy", int'(busy), 0);
    wait_tick(n);

    // back to 9
    step(1);
    push_per(80, 40, 2'd2); push_per(9, 5, 2'd0);
    step(10);
    req0_sel = 2'd0; req0_valid = 1'b1;
    rdy_q.push_back(2'b10); busy_q.push_back(69);
    wait_rdy(0);
    wait_tick(n);
    wait_tick(n);

    // accept on the tick cycle: switch with no busy window
    step(1);
    push_per(9, 5, 2'd0); push_per(12, 6, 2'd1);
    step(8);
    req0_sel = 2'd1; req0_valid = 1'b1;
    rdy_q.push_back(2'b10);
    wait_rdy(0);
    @(negedge clk);
    chk("tick_accept_busy", int'(busy), 0);
    chk("tick_accept_sel", int'(cur_sel), 1);
    wait_tick(n);

    // back to 9 again
    step(1);
    push_per(12, 6, 2'd1); push_per(9, 5, 2'd0);
    step(1);
    req0_sel = 2'd0; req0_valid = 1'b1;
    rdy_q.push_back(2'b10); busy_q.push_back(10);
    wait_rdy(0);
    wait_tick(n);
    wait_tick(n);

    // reset while a switch to 80 is pending discards it
    step(1);
    step(3);
    req0_sel = 2'd2; req0_valid = 1'b1;
    rdy_q.push_back(2'b10); busy_q.push_back(2);
    wait_rdy(0);
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    @(negedge clk);
    chk("pend_reset_busy", int'(busy), 0);
    chk("pend_reset_sel", int'(cur_sel), 0);
    wait_tick(n);
    chk("pend_reset_first_len", n, 9);
    step(1);
    push_per(9, 5, 2'd0); push_per(9, 5, 2'd0);
    wait_tick(n);
    wait_tick(n);

    step(2);
    chk("left_period", per_q.size(), 0);
    chk("left_ready", rdy_q.size(), 0);
    chk("left_busy", busy_q.size(), 0);
    chk("left_err", err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
